pipe_control_unit: RTL and testbench
====================================

# pipe_control_unit

Pipelined successor to the single-cycle control decoder. It decodes the RV32I instruction held in the IF/ID register and carries the resulting control bundle through ID/EX, EX/MEM and MEM/WB stage registers. It also detects load-use hazards (stall plus bubble) and taken branches or jumps (flush). It sits between the IF/ID register and the datapath stage muxes, and drives PC/IF-ID write enables.

## Interface
Parameters:
- XLEN, 32: instruction width; must be 32 for RV32I decode.
- RA_W, 5: register address width.

Ports:
- clk  in  1  rising-edge clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- id_instr  in  XLEN  instruction in IF/ID.
- id_valid  in  1  IF/ID holds a real instruction.
- ex_take  in  1  branch/jump in EX resolved taken (this cycle).
- pc_write  out  1  PC may advance.
- ifid_write  out  1  IF/ID may load.
- ifid_flush  out  1  IF/ID to be cleared next edge.
- ex_alu_op  out  2  00 add, 01 branch-compare, 10 funct-decoded.
- ex_alu_src  out  1  1 = immediate operand.
- ex_auipc_sel  out  1  1 = PC as operand A.
- ex_branch  out  1  EX holds branch/JAL/JALR.
- ex_rd  out  RA_W  destination of EX instruction.
- mem_read, mem_write  out  1 each  data-memory strobes (MEM stage).
- mem_save_method  out  2  00 byte, 01 half, 10 word.
- wb_reg_write  out  1  RF write enable (WB stage).
- wb_mem_to_reg  out  1  1 = load data to RF.
- wb_rf_sel  out  1  0 = PC+4/AUIPC path, 1 = ALU/mem path.
- illegal  out  1  sticky illegal-instruction flag (see Configuration).

## Operation
- Decode (combinational, ID): R, I-arith, LOAD, STORE, BRANCH, AUIPC, JAL, JALR as the single-cycle unit, with two corrections. Every output gets a defined default; unknown opcodes decode to an all-zero NOP bundle. STORE funct3 mapping: 000 maps to 00, 001 to 01, 010 to 10; other funct3 values decode as NOP.
- id_valid=0: the decoded bundle is forced to NOP.
- rs1 is "used" for R, I, LOAD, STORE, BRANCH and JALR. rs2 is "used" for R, STORE and BRANCH.
- Load-use hazard: stall = ID/EX holds a load AND ex_rd≠0 AND ex_rd equals a used rs1/rs2 of id_instr AND id_valid.
  - On stall: pc_write=0, ifid_write=0, and a NOP bubble is loaded into ID/EX next edge.
  - EX/MEM and MEM/WB advance normally.
- Flush: when ex_take=1, ifid_flush=1 and ID/EX loads NOP next edge; pc_write=1 and ifid_write=1 (redirect).
- Priority: flush over stall. When both are asserted, flush behaviour applies and the stall is dropped, because the stalled instruction is squashed.
- Normal case: the decoded bundle moves to ID/EX. EX fields advance to EX/MEM, and MEM fields advance to MEM/WB, every cycle; there is no back-pressure.
- Stage registers are plain flops with no enable except ID/EX bubble insertion.

## Timing
- Reset (async assert, synchronous deassert at the clock edge): all stage registers go to NOP, illegal=0, ex_rd=0. During reset pc_write=1, ifid_write=1 and ifid_flush=0.
- Control latency: an instruction decoded in ID in cycle n presents its EX fields in cycle n+1, its MEM fields in n+2 and its WB fields in n+3.
- pc_write, ifid_write and ifid_flush are combinational from the current ID/EX contents, id_instr and ex_take, in the same cycle.
- A stall lasts exactly one cycle per load, because the bubble removes the load from the ID/EX compare.
- Reset asserted mid-stall or mid-flush clears all in-flight bundles immediately. No partial bundle survives.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An unknown opcode, or a STORE with funct3 greater than 010, with id_valid=1 and no flush, sets illegal on the next edge.
  - illegal stays set until reset.
  - The offending instruction still proceeds as NOP.
- ILLEGAL_TRAP_EN undefined: illegal is tied to 0 and no flop is inferred.

## Structure
- Package ctrl_pkg holds:
  - the opcode constants;
  - the funct3 store codes;
  - the ALUOp and SaveMethod encodings;
  - the packed struct ctrl_t with fields alu_op, alu_src, auipc_sel, branch, mem_read, mem_write, save_method, reg_write, mem_to_reg, rf_sel, rd;
  - the constant CTRL_NOP, which is all zeros.
- Sub-module ctrl_decode is purely combinational, maps instruction to ctrl_t plus rs1_used, rs2_used and illegal_raw, and is reused by the single-cycle core.

## Test plan
- Reset: hold rst_n=0 with random id_instr -> all stage outputs are 0 and illegal=0; pc_write=1.
- Straight-line: ADD, then ADDI, then SW (funct3 010) -> after 1 cycle ex_alu_op=10 and ex_alu_src=0; after 2 cycles mem_write=1 with mem_save_method=10; wb_reg_write=1 follows for ADD and ADDI only.
- Load-use: LW x5 in EX, then ADD x6,x5,x1 in ID -> pc_write=0 and ifid_write=0 for exactly 1 cycle, then a bubble in EX; LW to x0 -> no stall.
- Flush: BEQ taken (ex_take=1) -> ifid_flush=1 and the next EX bundle is NOP; if a load-use condition is also present in the same cycle, pc_write=1 (flush wins).
- Illegal opcode 7'h7F with ILLEGAL_TRAP_EN -> illegal=1 from the next edge and sticky until reset, with a NOP bundle; without the macro -> illegal stays 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control definitions for the RV32I decoder and the pipelined control unit:
// opcodes, store funct3 codes, ALU/save encodings and the per-stage control bundles.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_FUNCT  = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SAVE_BYTE = 2'b00,
    SAVE_HALF = 2'b01,
    SAVE_WORD = 2'b10
  } save_method_e;

  typedef struct packed {
    alu_op_e      alu_op;
    logic         alu_src;
    logic         auipc_sel;
    logic         branch;
    logic         mem_read;
    logic         mem_write;
    save_method_e save_method;
    logic         reg_write;
    logic         mem_to_reg;
    logic         rf_sel;
    logic [4:0]   rd;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Bundles that survive past EX: only the fields their later stages still consume.
  typedef struct packed {
    logic         mem_read;
    logic         mem_write;
    save_method_e save_method;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic rf_sel;
  } wb_ctrl_t;

  typedef struct packed {
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } exmem_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I control decoder: instruction -> ctrl_t plus source-register usage
// and a raw illegal indication. Shared with the single-cycle core.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        rs1_used,
  output logic        rs2_used,
  output logic        illegal_raw
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [6:0] unused_funct7;

  assign opcode        = instr[6:0];
  assign rd            = instr[11:7];
  assign funct3        = instr[14:12];
  assign rs1           = instr[19:15];
  assign rs2           = instr[24:20];
  assign unused_funct7 = instr[31:25];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    ctrl        = CTRL_NOP;
    rs1_used    = 1'b0;
    rs2_used    = 1'b0;
    illegal_raw = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.alu_op    = ALU_FUNCT;
        ctrl.reg_write = 1'b1;
        ctrl.rf_sel    = 1'b1;
        ctrl.rd        = rd;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OP_I: begin
        ctrl.alu_op    = ALU_FUNCT;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.rf_sel    = 1'b1;
        ctrl.rd        = rd;
        rs1_used       = 1'b1;
      end
      OP_LOAD: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.rf_sel     = 1'b1;
        ctrl.rd         = rd;
        rs1_used        = 1'b1;
      end
      OP_STORE: begin
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        case (funct3)
          F3_SB:   ctrl.save_method = SAVE_BYTE;
          F3_SH:   ctrl.save_method = SAVE_HALF;
          F3_SW:   ctrl.save_method = SAVE_WORD;
          default: begin
            ctrl        = CTRL_NOP;
            illegal_raw = 1'b1;
          end
        endcase
      end
      OP_BRANCH: begin
        ctrl.alu_op = ALU_BRANCH;
        ctrl.branch = 1'b1;
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
      end
      // AUIPC and JAL write back through the PC-relative path, hence rf_sel = 0.
      OP_AUIPC: begin
        ctrl.alu_src   = 1'b1;
        ctrl.auipc_sel = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.rd        = rd;
      end
      OP_JAL: begin
        ctrl.alu_src   = 1'b1;
        ctrl.auipc_sel = 1'b1;
        ctrl.branch    = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.rd        = rd;
      end
      OP_JALR: begin
        ctrl.alu_src   = 1'b1;
        ctrl.branch    = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.rd        = rd;
        rs1_used       = 1'b1;
      end
      default: illegal_raw = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined RV32I control: decodes IF/ID, carries control through ID/EX, EX/MEM, MEM/WB,
// and handles load-use stalls and taken-branch flushes. Sticky illegal flag when ILLEGAL_TRAP_EN is defined.
module pipe_control_unit
  import ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] id_instr,
  input  logic            id_valid,
  input  logic            ex_take,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            ifid_flush,
  output logic [1:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic            ex_auipc_sel,
  output logic            ex_branch,
  output logic [RA_W-1:0] ex_rd,
  output logic            mem_read,
  output logic            mem_write,
  output logic [1:0]      mem_save_method,
  output logic            wb_reg_write,
  output logic            wb_mem_to_reg,
  output logic            wb_rf_sel,
  output logic            illegal
);

  ctrl_t      dec_ctrl;
  logic [4:0] rs1, rs2;
  logic       rs1_used, rs2_used, illegal_raw;

  ctrl_t    idex_d, idex_q;
  exmem_t   exmem_d, exmem_q;
  wb_ctrl_t memwb_d, memwb_q;
  logic     load_use, flush, stall;

  ctrl_decode u_decode (
    .instr       (id_instr),
    .ctrl        (dec_ctrl),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_used    (rs1_used),
    .rs2_used    (rs2_used),
    .illegal_raw (illegal_raw)
  );

  always_comb begin
    load_use = idex_q.mem_read && (idex_q.rd != '0) && id_valid &&
               ((rs1_used && (rs1 == idex_q.rd)) || (rs2_used && (rs2 == idex_q.rd)));
    flush    = ex_take;
    // A taken branch squashes the dependent instruction, so the stall is dropped.
    stall    = load_use && !flush;

    idex_d = dec_ctrl;
    if (!id_valid || stall || flush) idex_d = CTRL_NOP;

    exmem_d.mem.mem_read    = idex_q.mem_read;
    exmem_d.mem.mem_write   = idex_q.mem_write;
    exmem_d.mem.save_method = idex_q.save_method;
    exmem_d.wb.reg_write    = idex_q.reg_write;
    exmem_d.wb.mem_to_reg   = idex_q.mem_to_reg;
    exmem_d.wb.rf_sel       = idex_q.rf_sel;

    memwb_d = exmem_q.wb;
  end

  // NOTE: stage registers are ordinary flops reset to NOP; non-blocking so every stage samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q  <= CTRL_NOP;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign pc_write   = !stall;
  assign ifid_write = !stall;
  assign ifid_flush = flush && rst_n;

  assign ex_alu_op    = idex_q.alu_op;
  assign ex_alu_src   = idex_q.alu_src;
  assign ex_auipc_sel = idex_q.auipc_sel;
  assign ex_branch    = idex_q.branch;
  assign ex_rd        = RA_W'(idex_q.rd);

  assign mem_read        = exmem_q.mem.mem_read;
  assign mem_write       = exmem_q.mem.mem_write;
  assign mem_save_method = exmem_q.mem.save_method;

  assign wb_reg_write  = memwb_q.reg_write;
  assign wb_mem_to_reg = memwb_q.mem_to_reg;
  assign wb_rf_sel     = memwb_q.rf_sel;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_d, illegal_q;

  always_comb begin
    illegal_d = illegal_q || (illegal_raw && id_valid && !ex_take);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  logic unused_illegal_raw;
  assign unused_illegal_raw = illegal_raw;
  assign illegal            = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_control_unit.sv
// Randomized self-checking bench for pipe_control_unit against a stage-queue reference model.
module tb_pipe_control_unit;

  localparam logic [6:0] T_R = 7'h33, T_I = 7'h13, T_LD = 7'h03, T_ST = 7'h23;
  localparam logic [6:0] T_BR = 7'h63, T_AUIPC = 7'h17, T_JAL = 7'h6F, T_JALR = 7'h67;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] id_instr = '0;
  logic        id_valid = 1'b0;
  logic        ex_take = 1'b0;
  logic        pc_write, ifid_write, ifid_flush;
  logic [1:0]  ex_alu_op;
  logic        ex_alu_src, ex_auipc_sel, ex_branch;
  logic [4:0]  ex_rd;
  logic        mem_read, mem_write;
  logic [1:0]  mem_save_method;
  logic        wb_reg_write, wb_mem_to_reg, wb_rf_sel, illegal;

  pipe_control_unit #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid), .ex_take(ex_take),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_auipc_sel(ex_auipc_sel),
    .ex_branch(ex_branch), .ex_rd(ex_rd), .mem_read(mem_read), .mem_write(mem_write),
    .mem_save_method(mem_save_method), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_rf_sel(wb_rf_sel), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src, auipc, branch, mem_read, mem_write;
    logic [1:0] save;
    logic       reg_write, mem_to_reg, rf_sel;
    logic [4:0] rd;
  } exp_t;

  exp_t pipe_m[3];   // 0 = EX, 1 = MEM, 2 = WB
  logic ill_m;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [2:0] f3, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [6:0] f7);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  // What the control bundle of an instruction should mean, written as a table per class.
  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t e = '0;
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    case (op)
      T_R:     begin e.alu_op = 2'b10; e.reg_write = 1; e.rf_sel = 1; e.rd = ins[11:7]; end
      T_I:     begin e.alu_op = 2'b10; e.alu_src = 1; e.reg_write = 1; e.rf_sel = 1; e.rd = ins[11:7]; end
      T_LD:    begin e.alu_src = 1; e.mem_read = 1; e.reg_write = 1; e.mem_to_reg = 1;
                     e.rf_sel = 1; e.rd = ins[11:7]; end
      T_ST:    if (f3 <= 3'd2) begin e.alu_src = 1; e.mem_write = 1; e.save = f3[1:0]; end
      T_BR:    begin e.alu_op = 2'b01; e.branch = 1; end
      T_AUIPC: begin e.alu_src = 1; e.auipc = 1; e.reg_write = 1; e.rd = ins[11:7]; end
      T_JAL:   begin e.alu_src = 1; e.auipc = 1; e.branch = 1; e.reg_write = 1; e.rd = ins[11:7]; end
      T_JALR:  begin e.alu_src = 1; e.branch = 1; e.reg_write = 1; e.rd = ins[11:7]; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic ref_illegal(input logic [31:0] ins);
    logic [6:0] op = ins[6:0];
    if (!(op inside {T_R, T_I, T_LD, T_ST, T_BR, T_AUIPC, T_JAL, T_JALR})) return 1'b1;
    return (op == T_ST) && (ins[14:12] > 3'd2);
  endfunction

  function automatic logic ref_load_use(input logic [31:0] ins, input logic v, input exp_t ex);
    logic [6:0] op = ins[6:0];
    logic u1 = op inside {T_R, T_I, T_LD, T_ST, T_BR, T_JALR};
    logic u2 = op inside {T_R, T_ST, T_BR};
    return v && ex.mem_read && (ex.rd != 5'd0) &&
           ((u1 && ins[19:15] == ex.rd) || (u2 && ins[24:20] == ex.rd));
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".ex"},  {22'd0, ex_alu_op, ex_alu_src, ex_auipc_sel, ex_branch, ex_rd},
          {22'd0, pipe_m[0].alu_op, pipe_m[0].alu_src, pipe_m[0].auipc, pipe_m[0].branch, pipe_m[0].rd});
    check({tag, ".mem"}, {28'd0, mem_read, mem_write, mem_save_method},
          {28'd0, pipe_m[1].mem_read, pipe_m[1].mem_write, pipe_m[1].save});
    check({tag, ".wb"},  {29'd0, wb_reg_write, wb_mem_to_reg, wb_rf_sel},
          {29'd0, pipe_m[2].reg_write, pipe_m[2].mem_to_reg, pipe_m[2].rf_sel});
    check({tag, ".illegal"}, {31'd0, illegal}, {31'd0, ill_m});
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) pipe_m[i] = '0;
    ill_m = 1'b0;
  endtask

  // One cycle: drive ID inputs, check every output, then advance the model at the edge.
  task automatic step(input string tag, input logic [31:0] ins, input logic v, input logic take);
    logic st;
    @(negedge clk);
    id_instr = ins;
    id_valid = v;
    ex_take  = take;
    #1;
    st = ref_load_use(ins, v, pipe_m[0]) && !take;
    check({tag, ".pc_write"},   {31'd0, pc_write},   {31'd0, !st});
    check({tag, ".ifid_write"}, {31'd0, ifid_write}, {31'd0, !st});
    check({tag, ".ifid_flush"}, {31'd0, ifid_flush}, {31'd0, take});
    check_outputs(tag);
    @(posedge clk);
    pipe_m[2] = pipe_m[1];
    pipe_m[1] = pipe_m[0];
    pipe_m[0] = (st || take || !v) ? exp_t'('0) : ref_decode(ins);
`ifdef ILLEGAL_TRAP_EN
    ill_m = ill_m | (ref_illegal(ins) && v && !take);
`endif
  endtask

  // Assert reset mid-cycle; everything in flight must vanish at once.
  task automatic reset_now(input string tag);
    @(negedge clk);
    #2;
    id_instr = $urandom;
    ex_take  = 1'b1;
    id_valid = 1'b1;
    rst_n    = 1'b0;
    clear_model();
    #1;
    check({tag, ".pc_write"},   {31'd0, pc_write},   32'd1);
    check({tag, ".ifid_write"}, {31'd0, ifid_write}, 32'd1);
    check({tag, ".ifid_flush"}, {31'd0, ifid_flush}, 32'd0);
    check_outputs(tag);
    @(negedge clk);
    check({tag, ".held"}, {22'd0, ex_alu_op, ex_alu_src, ex_auipc_sel, ex_branch, ex_rd}, 32'd0);
    id_valid = 1'b0;
    ex_take  = 1'b0;
    rst_n    = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] bad_ops[5] = '{7'h7F, 7'h37, 7'h0F, 7'h73, 7'h00};
    logic [4:0] rd  = 5'($urandom_range(0, 3));
    logic [4:0] rs1 = 5'($urandom_range(0, 3));
    logic [4:0] rs2 = 5'($urandom_range(0, 3));
    logic [2:0] f3  = 3'($urandom_range(0, 7));
    logic [6:0] f7  = 7'($urandom);
    case ($urandom_range(0, 9))
      0: return enc(T_R, rd, f3, rs1, rs2, f7);
      1: return enc(T_I, rd, f3, rs1, rs2, f7);
      2: return enc(T_LD, rd, f3, rs1, rs2, f7);
      3: return enc(T_ST, rd, 3'($urandom_range(0, 2)), rs1, rs2, f7);
      4: return enc(T_BR, rd, f3, rs1, rs2, f7);
      5: return enc(T_AUIPC, rd, f3, rs1, rs2, f7);
      6: return enc(T_JAL, rd, f3, rs1, rs2, f7);
      7: return enc(T_JALR, rd, f3, rs1, rs2, f7);
      8: return enc(bad_ops[$urandom_range(0, 4)], rd, f3, rs1, rs2, f7);
      default: return enc(T_ST, rd, 3'($urandom_range(3, 7)), rs1, rs2, f7);
    endcase
  endfunction

  initial begin
    logic [31:0] add_dep;
    clear_model();

    // Reset held with random inputs, flush request included.
    rst_n    = 1'b0;
    id_valid = 1'b1;
    ex_take  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      id_instr = $urandom;
      #1;
      check("rst.pc_write",   {31'd0, pc_write},   32'd1);
      check("rst.ifid_write", {31'd0, ifid_write}, 32'd1);
      check("rst.ifid_flush", {31'd0, ifid_flush}, 32'd0);
      check_outputs("rst");
    end
    id_valid = 1'b0;
    ex_take  = 1'b0;
    rst_n    = 1'b1;

    // Straight-line ADD, ADDI, SW then drain.
    step("add",  enc(T_R, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0), 1, 0);
    step("addi", enc(T_I, 5'd4, 3'd0, 5'd1, 5'd0, 7'd0), 1, 0);
    step("sw",   enc(T_ST, 5'd8, 3'd2, 5'd1, 5'd3, 7'd0), 1, 0);
    for (int i = 0; i < 3; i++) step("drain", 32'h0, 0, 0);

    // Load-use: one stall cycle, then bubble; LW to x0 never stalls.
    add_dep = enc(T_R, 5'd6, 3'd0, 5'd5, 5'd1, 7'd0);
    step("lw",       enc(T_LD, 5'd5, 3'd2, 5'd1, 5'd0, 7'd0), 1, 0);
    step("lu.stall", add_dep, 1, 0);
    step("lu.go",    add_dep, 1, 0);
    step("lw0",      enc(T_LD, 5'd0, 3'd2, 5'd1, 5'd0, 7'd0), 1, 0);
    step("lw0.use",  enc(T_R, 5'd6, 3'd0, 5'd0, 5'd0, 7'd0), 1, 0);

    // Taken branch while a load-use is pending: flush wins.
    step("beq",      enc(T_BR, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0), 1, 0);
    step("beq.take", enc(T_I, 5'd7, 3'd0, 5'd1, 5'd0, 7'd0), 1, 1);
    step("lw.b",     enc(T_LD, 5'd5, 3'd2, 5'd1, 5'd0, 7'd0), 1, 0);
    step("flush.lu", add_dep, 1, 1);
    step("after",    32'h0, 0, 0);

    // Illegal opcode, then sticky over following traffic.
    step("ill",     32'h0000_007F, 1, 0);
    for (int i = 0; i < 4; i++) step("ill.hold", enc(T_R, 5'd1, 3'd0, 5'd2, 5'd3, 7'd0), 1, 0);
    reset_now("rst.mid1");

    // Randomized traffic with one mid-stream reset.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) reset_now("rst.mid2");
      step("rnd", rand_instr(), $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
